icache_direct: RTL and testbench

- Read-only, direct-mapped instruction cache between the pipeline's instruction-fetch port (ICACHE_*) and the shared 128-bit instruction memory.
- Returns hit data combinationally in the request cycle.
- On a miss, holds proc_stall high while it fetches a 4-word line, then returns data from the refilled line.
- Write requests are not supported and are ignored.

---
 rtl/icache_pkg.sv | 19 +
 rtl/icache_line_store.sv | 43 ++++
 rtl/icache_direct.sv | 108 ++++++++++
 tb/tb_icache_direct.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared widths, FSM state type and geometry helpers for the direct-mapped
// instruction cache.
package icache_pkg;
   localparam int unsigned LINE_W   = 128;
   localparam int unsigned WORD_W   = 32;
   localparam int unsigned OFFSET_W = 2;
   localparam int unsigned ADDR_W   = 30;
   localparam int unsigned LADDR_W  = ADDR_W - OFFSET_W;

   typedef enum logic {IDLE, FETCH} state_t;

   function automatic int unsigned idx_width(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_width(input int unsigned num_lines);
      return LADDR_W - $clog2(num_lines);
   endfunction
endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage: one write port for refills, one asynchronous read port.
module icache_line_store
   import icache_pkg::*;
#(
   parameter int unsigned NUM_LINES = 8,
   parameter int unsigned IDX_W     = 3,
   parameter int unsigned TAG_W     = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_line,
   input  logic              wen,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_line
);
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
   logic [LINE_W-1:0]    data_mem [NUM_LINES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wen) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tag and data contents are only meaningful behind a set valid bit.
   always_ff @(posedge clk) begin
      if (wen) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_line;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_line  = data_mem[rd_idx];
endmodule

// File: rtl/icache_direct.sv
// Read-only direct-mapped instruction cache: combinational hit path, stalls the
// fetch port while a 4-word line is refilled from the 128-bit memory.
module icache_direct
   import icache_pkg::*;
#(
   parameter int unsigned NUM_LINES = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                proc_read,
   input  logic                proc_write,
   input  logic [ADDR_W-1:0]   proc_addr,
   input  logic [WORD_W-1:0]   proc_wdata,
   output logic [WORD_W-1:0]   proc_rdata,
   output logic                proc_stall,
   output logic                mem_read,
   output logic                mem_write,
   output logic [LADDR_W-1:0]  mem_addr,
   output logic [LINE_W-1:0]   mem_wdata,
   input  logic [LINE_W-1:0]   mem_rdata,
   input  logic                mem_ready
);
   localparam int unsigned IDX_W = idx_width(NUM_LINES);
   localparam int unsigned TAG_W = tag_width(NUM_LINES);

   state_t              state, state_next;
   logic [IDX_W-1:0]    rd_idx;
   logic [TAG_W-1:0]    rd_tag;
   logic                line_valid;
   logic [TAG_W-1:0]    line_tag;
   logic [LINE_W-1:0]   line_data;
   logic                hit, fill, load_miss;
   logic                unused_ok;

   assign rd_idx = proc_addr[IDX_W+1:2];
   assign rd_tag = proc_addr[ADDR_W-1:IDX_W+2];

   icache_line_store #(
      .NUM_LINES (NUM_LINES),
      .IDX_W     (IDX_W),
      .TAG_W     (TAG_W)
   ) u_store (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_idx   (mem_addr[IDX_W-1:0]),
      .wr_tag   (mem_addr[LADDR_W-1:IDX_W]),
      .wr_line  (mem_rdata),
      .wen      (fill),
      .rd_idx   (rd_idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_line  (line_data)
   );

   assign hit = proc_read & line_valid & (line_tag == rd_tag);

   // A miss seen while reset is held must not stall the pipeline.
   always_comb begin
      state_next = state;
      proc_stall = 1'b0;
      load_miss  = 1'b0;
      fill       = 1'b0;
      case (state)
         IDLE: begin
            if (proc_read && !hit) begin
               proc_stall = rst_n;
               load_miss  = 1'b1;
               state_next = FETCH;
            end
         end
         FETCH: begin
            proc_stall = 1'b1;
            if (mem_ready) begin
               fill       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      proc_rdata = '0;
      if (hit) begin
         proc_rdata = line_data[{proc_addr[1:0], 5'b0} +: WORD_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mem_read <= 1'b0;
         mem_addr <= '0;
      end else begin
         state <= state_next;
         if (load_miss) begin
            mem_read <= 1'b1;
            mem_addr <= proc_addr[ADDR_W-1:OFFSET_W];
         end else if (fill) begin
            mem_read <= 1'b0;
         end
      end
   end

   assign mem_write = 1'b0;
   assign mem_wdata = '0;
   assign unused_ok = ^{proc_write, proc_wdata};
endmodule

// File: tb/tb_icache_direct.sv
// Directed and randomized fetch sequences for icache_direct, checked against a
// line-address-level model of cache contents and a deterministic memory image.
module tb_icache_direct;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int checks = 0;
   int errors = 0;
   int stall_cnt;

   // Model: which memory line (full line address) each of the 8 slots holds.
   bit          mvalid [8];
   logic [27:0] mla    [8];

   icache_direct #(.NUM_LINES(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [127:0] memline(input logic [27:0] la);
      logic [127:0] l;
      if (la == 28'h4) begin
         l = {32'h33, 32'h22, 32'h11, 32'h00};
      end else begin
         for (int unsigned k = 0; k < 4; k++)
            l[k*32 +: 32] = {la[19:0], 12'(k)} ^ 32'h5A5A_0000;
      end
      return l;
   endfunction

   function automatic logic [31:0] memword(input logic [29:0] a);
      logic [127:0] l;
      l = memline(a[29:2]);
      return l[{a[1:0], 5'b0} +: 32];
   endfunction

   function automatic bit model_hit(input logic [29:0] a);
      return mvalid[a[4:2]] && (mla[a[4:2]] == a[29:2]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at posedge+1 of the first FETCH cycle; leaves at posedge+1 after the fill edge.
   task automatic run_fetch(input logic [27:0] la, input int lat);
      for (int i = 1; i <= lat; i++) begin
         mem_ready = (i == lat);
         mem_rdata = (i == lat) ? memline(la) : {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check("fetch_stall", 128'(proc_stall), 128'(1));
         check("fetch_mem_read", 128'(mem_read), 128'(1));
         check("fetch_mem_addr", 128'(mem_addr), 128'(la));
         if (proc_stall) stall_cnt++;
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
      mvalid[la[2:0]] = 1'b1;
      mla[la[2:0]]    = la;
   endtask

   // Entered and left at posedge+1.
   task automatic access(input logic [29:0] a, input int lat);
      proc_read  = 1'b1;
      proc_write = 1'b0;
      proc_addr  = a;
      @(negedge clk);
      if (model_hit(a)) begin
         check("hit_stall", 128'(proc_stall), 128'(0));
         check("hit_rdata", 128'(proc_rdata), 128'(memword(a)));
         check("hit_mem_read", 128'(mem_read), 128'(0));
         @(posedge clk);
         #1;
      end else begin
         check("miss_stall", 128'(proc_stall), 128'(1));
         stall_cnt = 1;
         @(posedge clk);
         #1;
         run_fetch(a[29:2], lat);
         @(negedge clk);
         check("refill_stall", 128'(proc_stall), 128'(0));
         check("refill_rdata", 128'(proc_rdata), 128'(memword(a)));
         check("stall_cycles", 128'(stall_cnt), 128'(1 + lat));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      proc_read  = 1'b1;
      proc_write = 1'b0;
      proc_addr  = 30'h10;
      proc_wdata = '0;
      mem_rdata  = '0;
      mem_ready  = 1'b0;
      model_clear();

      // Outputs while reset is held, even with a request pending.
      #3;
      check("rst_stall", 128'(proc_stall), 128'(0));
      check("rst_rdata", 128'(proc_rdata), 128'(0));
      check("rst_mem_read", 128'(mem_read), 128'(0));
      check("rst_mem_addr", 128'(mem_addr), 128'(0));
      check("rst_mem_write", 128'(mem_write), 128'(0));
      check("rst_mem_wdata", mem_wdata, 128'(0));
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      proc_read = 1'b0;

      // Cold miss with latency 3, then hits across the filled line.
      access(30'h10, 3);
      access(30'h11, 2);
      access(30'h12, 2);
      access(30'h13, 2);

      // Conflict on index 4: 0x30 evicts 0x10, zero-wait refill of 0x10.
      access(30'h10, 2);
      access(30'h30, 2);
      access(30'h10, 1);

      // Idle cycles with writes and stray mem_ready pulses.
      for (int i = 0; i < 6; i++) begin
         proc_read  = 1'b0;
         proc_write = 1'b1;
         proc_addr  = 30'($urandom);
         proc_wdata = $urandom;
         mem_ready  = (i % 2 == 1);
         mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         check("idle_stall", 128'(proc_stall), 128'(0));
         check("idle_mem_read", 128'(mem_read), 128'(0));
         @(posedge clk);
         #1;
      end
      mem_ready = 1'b0;
      access(30'h12, 2);

      // Fetch address moves away mid-refill; the latched line still lands.
      proc_read = 1'b1;
      proc_addr = 30'h20;
      @(negedge clk);
      check("chg_miss_stall", 128'(proc_stall), 128'(model_hit(30'h20) ? 0 : 1));
      stall_cnt = 1;
      @(posedge clk);
      #1;
      proc_addr = 30'h40;
      run_fetch(28'h8, 3);
      proc_addr = 30'h20;
      @(negedge clk);
      check("chg_installed_stall", 128'(proc_stall), 128'(0));
      check("chg_installed_rdata", 128'(proc_rdata), 128'(memword(30'h20)));
      @(posedge clk);
      #1;
      access(30'h40, 2);
      access(30'h20, 1);

      // Reset in the second FETCH cycle aborts the refill.
      access(30'h10, 1);
      proc_read = 1'b1;
      proc_addr = 30'h54;
      @(negedge clk);
      check("abort_miss_stall", 128'(proc_stall), 128'(1));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("abort_fetch1_mem_read", 128'(mem_read), 128'(1));
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_mem_read", 128'(mem_read), 128'(0));
      check("abort_stall", 128'(proc_stall), 128'(0));
      check("abort_mem_addr", 128'(mem_addr), 128'(0));
      model_clear();
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      proc_read = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = memline(28'h15);
      @(negedge clk);
      check("late_ready_mem_read", 128'(mem_read), 128'(0));
      check("late_ready_stall", 128'(proc_stall), 128'(0));
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      access(30'h54, 2);
      access(30'h10, 2);

      // Randomized fetch stream over a few tags per index.
      for (int i = 0; i < 40; i++) begin
         access(30'(($urandom_range(0, 3) << 5) | $urandom_range(0, 31)),
                int'($urandom_range(1, 4)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
